// File: rtl/ha_serial_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : ha_serial_add_sched
// Function : Round-robin scheduler sharing one external half-adder between
//            two requesters; two half-add passes per bit form a full add.
// Revision : 1.0
// ============================================================================
module ha_serial_add_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             ha_x,
   output logic             ha_y,
   input  logic             ha_s,
   input  logic             ha_c
);

   localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_P1   = 2'd1,
      S_P2   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [WIDTH-1:0]     r_sum;
   logic [c_IDX_W-1:0]   r_idx;
   logic                 r_carry;
   logic                 r_c1;
   logic                 r_cout;
   logic                 r_id;
   logic                 r_last_grant;
   logic                 r_rsp_valid;
   logic                 r_ha_x;
   logic                 r_ha_y;

   logic                 w_any;
   logic                 w_gnt;
   logic                 w_idle;
   logic                 w_acc;
   logic [WIDTH-1:0]     w_a_sel;
   logic [WIDTH-1:0]     w_b_sel;
   logic                 w_c_sum;
   logic                 w_last_bit;
   logic [c_IDX_W-1:0]   w_idx_nxt;

   // Ready is held low while rst is high so no handshake is seen during reset.
   assign w_any      = req0_valid | req1_valid;
   assign w_gnt      = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
   assign w_idle     = (r_state == S_IDLE) & ~rst;
   assign req0_ready = w_idle & w_any & ~w_gnt;
   assign req1_ready = w_idle & w_any & w_gnt;
   assign w_acc      = req0_ready | req1_ready;
   assign w_a_sel    = w_gnt ? req1_a : req0_a;
   assign w_b_sel    = w_gnt ? req1_b : req0_b;
   assign w_c_sum    = r_c1 | ha_c;
   assign w_last_bit = (r_idx == c_LAST_IDX);
   assign w_idx_nxt  = r_idx + c_IDX_W'(1);

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_id;
   assign rsp_sum    = r_sum;
   assign rsp_cout   = r_cout;
   assign ha_x       = r_ha_x;
   assign ha_y       = r_ha_y;

   // ha_x/ha_y are loaded one state ahead so they are valid throughout P1/P2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_sum        <= '0;
         r_idx        <= '0;
         r_carry      <= 1'b0;
         r_c1         <= 1'b0;
         r_cout       <= 1'b0;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_ha_x       <= 1'b0;
         r_ha_y       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_acc) begin
                  r_a          <= w_a_sel;
                  r_b          <= w_b_sel;
                  r_id         <= w_gnt;
                  r_last_grant <= w_gnt;
                  r_carry      <= 1'b0;
                  r_idx        <= '0;
                  r_sum        <= '0;
                  r_cout       <= 1'b0;
                  r_ha_x       <= w_a_sel[0];
                  r_ha_y       <= w_b_sel[0];
                  r_state      <= S_P1;
               end
            end
            S_P1: begin
               // r_ha_x now carries the first-pass sum into the second pass.
               r_c1    <= ha_c;
               r_ha_x  <= ha_s;
               r_ha_y  <= r_carry;
               r_state <= S_P2;
            end
            S_P2: begin
               r_sum[r_idx] <= ha_s;
               r_carry      <= w_c_sum;
               if (w_last_bit) begin
                  r_cout      <= w_c_sum;
                  r_ha_x      <= 1'b0;
                  r_ha_y      <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx   <= w_idx_nxt;
                  r_ha_x  <= r_a[w_idx_nxt];
                  r_ha_y  <= r_b[w_idx_nxt];
                  r_state <= S_P1;
               end
            end
            S_DONE: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ha_serial_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ha_serial_add_sched
// Function : Directed bench with a cycle-level arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_ha_serial_add_sched;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_cout;
   logic [WIDTH-1:0] rsp_sum;
   logic             ha_x, ha_y, ha_s, ha_c;

   always #5 clk = ~clk;

   assign ha_s = ha_x ^ ha_y;
   assign ha_c = ha_x & ha_y;

   ha_serial_add_sched #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .ha_x       (ha_x),
      .ha_y       (ha_y),
      .ha_s       (ha_s),
      .ha_c       (ha_c)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int lowmask(input int k);
      return (1 << k) - 1;
   endfunction

   // Reference model: phase 0 idle, 1 computing (m_e edges elapsed), 2 result held.
   int m_phase = 0;
   int m_e     = 0;
   int m_a     = 0;
   int m_b     = 0;
   int m_full  = 0;
   int m_id    = 0;
   int m_last  = 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_e = 0; m_a = 0; m_b = 0; m_full = 0; m_id = 0; m_last = 1;
      end else begin
         case (m_phase)
            0: if (req0_valid || req1_valid) begin
               m_id   = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
               m_last = m_id;
               m_a    = m_id ? int'(req1_a) : int'(req0_a);
               m_b    = m_id ? int'(req1_b) : int'(req0_b);
               m_full = m_a + m_b;
               m_e    = 0;
               m_phase = 1;
            end
            1: begin
               m_e++;
               if (m_e == 2 * WIDTH) m_phase = 2;
            end
            default: if (rsp_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin : cmp
      int bi;
      int e_sum, e_cout, e_x, e_y, e_r0, e_r1;
      bi     = m_e / 2;
      e_sum  = (m_phase == 1) ? (m_full & lowmask(bi)) : (m_full & lowmask(WIDTH));
      e_cout = (m_phase == 1) ? 0 : ((m_full >> WIDTH) & 1);
      e_x = 0;
      e_y = 0;
      if (m_phase == 1) begin
         if (m_e % 2 == 0) begin
            e_x = (m_a >> bi) & 1;
            e_y = (m_b >> bi) & 1;
         end else begin
            e_x = ((m_a ^ m_b) >> bi) & 1;
            e_y = (((m_a & lowmask(bi)) + (m_b & lowmask(bi))) >> bi) & 1;
         end
      end
      e_r0 = (!rst && m_phase == 0 && req0_valid && (!req1_valid || m_last == 1)) ? 1 : 0;
      e_r1 = (!rst && m_phase == 0 && req1_valid && (!req0_valid || m_last == 0)) ? 1 : 0;
      chk("rsp_valid",  32'(rsp_valid),  (m_phase == 2) ? 32'd1 : 32'd0);
      chk("rsp_id",     32'(rsp_id),     32'(m_id));
      chk("rsp_sum",    32'(rsp_sum),    32'(e_sum));
      chk("rsp_cout",   32'(rsp_cout),   32'(e_cout));
      chk("ha_x",       32'(ha_x),       32'(e_x));
      chk("ha_y",       32'(ha_y),       32'(e_y));
      chk("req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(req1_ready), 32'(e_r1));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (id == 0) begin req0_valid = v; req0_a = a; req0_b = b; end
      else         begin req1_valid = v; req1_a = a; req1_b = b; end
   endtask

   // One add with literal expectations; hold>0 stalls rsp_ready in DONE.
   task automatic run_add(input string tag, input int id, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e_sum,
                          input logic e_cout, input int hold);
      bit got;
      int lat;
      set_req(id, 1'b1, a, b);
      rsp_ready = (hold == 0);
      got = 0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         got = (id == 0) ? req0_ready : req1_ready;
      end
      chk({tag, " accepted"}, 32'(got), 32'd1);
      if (!got) begin
         set_req(id, 1'b0, a, b);
         return;
      end
      tick();
      set_req(id, 1'b0, a, b);
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(2 * WIDTH));
      chk({tag, " sum"},     32'(rsp_sum),  32'(e_sum));
      chk({tag, " cout"},    32'(rsp_cout), 32'(e_cout));
      chk({tag, " id"},      32'(rsp_id),   32'(id));
      for (int k = 0; k < hold; k++) begin
         tick();
         chk({tag, " held valid"}, 32'(rsp_valid), 32'd1);
         chk({tag, " held sum"},   32'(rsp_sum),   32'(e_sum));
         chk({tag, " held ha"},    32'({ha_x, ha_y}), 32'd0);
         chk({tag, " no accept"},  32'(req0_ready | req1_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      chk({tag, " released"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_total=%0d", n_pass, n_total);
      $fatal(1);
   end

   initial begin : stim
      int seen;
      int order [4];
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;

      // Reset with random inputs; the model expects all outputs at zero.
      for (int k = 0; k < 4; k++) begin
         tick();
         req0_valid = 1'($urandom); req1_valid = 1'($urandom); rsp_ready = 1'($urandom);
         req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom);
         req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom);
      end
      #3;
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset ready",     32'(req0_ready | req1_ready), 32'd0);
      tick();
      rst = 1'b0;
      set_req(0, 1'b1, 8'hA5, 8'h3C);
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      #3;
      chk("ready after reset", 32'(req0_ready), 32'd1);

      run_add("single", 0, 8'hA5, 8'h3C, 8'hE1, 1'b0, 0);
      run_add("carry",  1, 8'hFF, 8'h01, 8'h00, 1'b1, 0);
      run_add("nostale", 1, 8'h00, 8'h00, 8'h00, 1'b0, 0);

      // Arbitration from reset with both requesters held valid.
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(0, 1'b1, 8'h12, 8'h34);
      set_req(1, 1'b1, 8'h80, 8'h90);
      rsp_ready = 1'b1;
      order = '{0, 1, 0, 1};
      for (int r = 0; r < 4; r++) begin
         seen = 0;
         while (!rsp_valid && seen < 100) begin
            tick();
            seen++;
         end
         chk("arb response", 32'(rsp_valid), 32'd1);
         chk("arb order",    32'(rsp_id),    32'(order[r]));
         chk("arb sum",      32'(rsp_sum),   (order[r] == 0) ? 32'h46 : 32'h10);
         chk("arb cout",     32'(rsp_cout),  (order[r] == 0) ? 32'd0 : 32'd1);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      // Backpressure with requester 1 waiting throughout.
      set_req(1, 1'b1, 8'h55, 8'h0A);
      run_add("backpressure", 0, 8'h33, 8'h44, 8'h77, 1'b0, 5);
      run_add("waiter", 1, 8'h55, 8'h0A, 8'h5F, 1'b0, 0);

      // Abort in P2 of bit 3: seven edges after the accept edge.
      set_req(0, 1'b1, 8'h0F, 8'h0F);
      seen = 0;
      while (!req0_ready && seen < 100) begin
         @(negedge clk);
         seen++;
      end
      tick();
      req0_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      chk("pre-abort partial sum", 32'(rsp_sum), 32'h06);
      rst = 1'b1;
      #1;
      chk("abort valid", 32'(rsp_valid), 32'd0);
      chk("abort sum",   32'(rsp_sum),   32'd0);
      chk("abort ha",    32'({ha_x, ha_y}), 32'd0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("no response after abort", 32'(rsp_valid), 32'd0);
      end
      run_add("after abort", 0, 8'h7F, 8'h01, 8'h80, 1'b0, 0);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
